// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit arbiter and its helpers.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LAUNCH,
    WAIT,
    ACK,
    ERR
  } arb_state_t;

  localparam int BAUD_4800   = 10416;
  localparam int BAUD_9600   = 5208;
  localparam int BAUD_115200 = 434;
  localparam int FRAME_BITS  = 10;

  // Next power of two above one full frame at the slowest baud (131072).
  localparam int DEF_TIMEOUT_CYC = 2 ** $clog2(BAUD_4800 * FRAME_BITS);

endpackage

// File: rtl/uart_rr_pick.sv
// Combinational rotate-priority picker: first set req bit at or above ptr, with wrap-around.
module uart_rr_pick #(
  parameter int N_REQ = 4,
  parameter int IDX_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic             valid,
  output logic [IDX_W-1:0] index
);

  int               pos;
  logic [IDX_W-1:0] pos_idx;

  // Scan from farthest to nearest offset so the nearest hit is the last one written.
  always_comb begin
    valid   = 1'b0;
    index   = '0;
    pos     = 0;
    pos_idx = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      pos = int'(ptr) + k;
      if (pos >= N_REQ) pos = pos - N_REQ;
      pos_idx = IDX_W'(pos);
      if (req[pos_idx]) begin
        valid = 1'b1;
        index = pos_idx;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one send_byte transmitter among N_REQ byte requesters.
// Optional tx_done watchdog and err output enabled by UART_ARB_TIMEOUT_EN.
//
// state  | meaning
// IDLE   | no grant; picker evaluated every cycle
// LAUNCH | send_go pulse to send_byte with latched byte
// WAIT   | waiting for tx_done from send_byte
// ACK    | ack pulse to winner, pointer advances
// ERR    | tx_done never came; ack + err, pointer advances
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int IDX_W = $clog2(N_REQ)
`ifdef UART_ARB_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
`endif
) (
  input  logic               sys_clk,
  input  logic               rst_n,
  input  logic [N_REQ-1:0]   req,
  input  logic [N_REQ*8-1:0] req_data,
  output logic [N_REQ-1:0]   ack,
  output logic               busy,
  output logic [IDX_W-1:0]   gnt_id,
  output logic               send_go,
  output logic [7:0]         send_data,
  input  logic               tx_done
`ifdef UART_ARB_TIMEOUT_EN
  ,
  output logic               err
`endif
);

  arb_state_t       state, state_nxt;
  logic [IDX_W-1:0] ptr;
  logic             pick_valid;
  logic [IDX_W-1:0] pick_idx;
  logic [N_REQ-1:0] ack_nxt;
  logic             tmo_hit;

  uart_rr_pick #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_pick (
    .req   (req),
    .ptr   (ptr),
    .valid (pick_valid),
    .index (pick_idx)
  );

`ifdef UART_ARB_TIMEOUT_EN
  logic [31:0] tmo_cnt;

  // Down-counter loaded while launching; terminal count 0 marks TIMEOUT_CYC cycles in WAIT.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_cnt <= '0;
    end else if (state == LAUNCH) begin
      tmo_cnt <= 32'(TIMEOUT_CYC - 1);
    end else if (state == WAIT && tmo_cnt != '0) begin
      tmo_cnt <= tmo_cnt - 1'b1;
    end
  end

  assign tmo_hit = (tmo_cnt == '0);
`else
  assign tmo_hit = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    ack_nxt   = '0;
    case (state)
      IDLE:    if (pick_valid) state_nxt = LAUNCH;
      LAUNCH:  state_nxt = WAIT;
      WAIT: begin
        if (tx_done)      state_nxt = ACK;
        else if (tmo_hit) state_nxt = ERR;
      end
      ACK, ERR: state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
    if (state_nxt == ACK || state_nxt == ERR) ack_nxt[gnt_id] = 1'b1;
  end

  // Outputs are registered from the next state so they line up with the state they describe.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      ptr       <= '0;
      gnt_id    <= '0;
      send_data <= 8'h00;
      send_go   <= 1'b0;
      busy      <= 1'b0;
      ack       <= '0;
    end else begin
      state   <= state_nxt;
      send_go <= (state_nxt == LAUNCH);
      busy    <= (state_nxt != IDLE);
      ack     <= ack_nxt;
      if (state == IDLE && pick_valid) begin
        gnt_id    <= pick_idx;
        send_data <= req_data[{pick_idx, 3'b000} +: 8];
      end
      if (state == ACK || state == ERR) begin
        ptr <= (gnt_id == IDX_W'(N_REQ - 1)) ? '0 : gnt_id + 1'b1;
      end
    end
  end

`ifdef UART_ARB_TIMEOUT_EN
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) err <= 1'b0;
    else        err <= (state_nxt == ERR);
  end
`endif

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter; timeout scenario runs when UART_ARB_TIMEOUT_EN is defined.
module tb_uart_tx_arbiter;

  logic        sys_clk = 1'b0;
  logic        rst_n   = 1'b0;
  logic [3:0]  req     = '0;
  logic [31:0] req_data = '0;
  logic        tx_done = 1'b0;
  logic [3:0]  ack;
  logic        busy;
  logic [1:0]  gnt_id;
  logic        send_go;
  logic [7:0]  send_data;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;
  int go_cyc = 0;
  int n_launch = 0;
  bit auto_tx  = 1'b1;
  bit hold_req = 1'b0;
  bit in_flight = 1'b0;
  int tx_delay = 20;

  logic [9:0] exp_launch_q[$];
  logic [3:0] exp_ack_q[$];

`ifdef UART_ARB_TIMEOUT_EN
  logic err;
  uart_tx_arbiter #(.N_REQ(4), .TIMEOUT_CYC(100)) dut (
    .sys_clk(sys_clk), .rst_n(rst_n), .req(req), .req_data(req_data),
    .ack(ack), .busy(busy), .gnt_id(gnt_id), .send_go(send_go),
    .send_data(send_data), .tx_done(tx_done), .err(err));
`else
  uart_tx_arbiter #(.N_REQ(4)) dut (
    .sys_clk(sys_clk), .rst_n(rst_n), .req(req), .req_data(req_data),
    .ack(ack), .busy(busy), .gnt_id(gnt_id), .send_go(send_go),
    .send_data(send_data), .tx_done(tx_done));
`endif

  always #5 sys_clk = ~sys_clk;
  always @(posedge sys_clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_chk++;
    n_fail++;
    $display("FAIL %s: got event/timeout expected none (t=%0t)", name, $time);
  endtask

  task automatic push(input logic [1:0] idx, input logic [7:0] data);
    logic [3:0] oh;
    oh = 4'b0001 << idx;
    exp_launch_q.push_back({idx, data});
    exp_ack_q.push_back(oh);
  endtask

  task automatic wait_idle(input int budget);
    int i = 0;
    while ((busy || exp_launch_q.size() != 0 || exp_ack_q.size() != 0) && i < budget) begin
      @(negedge sys_clk);
      i++;
    end
    if (i >= budget) fail_now("wait_idle_timeout");
    @(posedge sys_clk); #1;
  endtask

  // Monitor: compares launches and acks against the scoreboard queues.
  initial forever begin
    logic [9:0] e;
    @(negedge sys_clk);
    if (!rst_n) in_flight = 1'b0;
    if (send_go) begin
      n_launch++;
      go_cyc = cyc;
      chk("no_second_launch", in_flight, 0);
      in_flight = 1'b1;
      if (exp_launch_q.size() == 0) fail_now("unexpected_send_go");
      else begin
        e = exp_launch_q.pop_front();
        chk("gnt_id", gnt_id, e[9:8]);
        chk("send_data", send_data, e[7:0]);
      end
    end
    if (ack != '0) begin
      in_flight = 1'b0;
      if (exp_ack_q.size() == 0) fail_now("unexpected_ack");
      else chk("ack", ack, exp_ack_q.pop_front());
      chk("busy_in_ack", busy, 1);
    end
  end

  // Requesters drop their request on seeing ack.
  initial forever begin
    @(negedge sys_clk);
    if (ack != '0 && !hold_req) req = req & ~ack;
  end

  // send_byte stand-in: fixed frame delay then one tx_done pulse.
  initial forever begin
    @(negedge sys_clk);
    if (send_go && auto_tx) begin
      repeat (tx_delay) @(negedge sys_clk);
      tx_done = 1'b1;
      @(negedge sys_clk);
      tx_done = 1'b0;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int i;
    repeat (3) @(posedge sys_clk);
    #1;
    chk("rst_ack", ack, 0);
    chk("rst_busy", busy, 0);
    chk("rst_gnt_id", gnt_id, 0);
    chk("rst_send_go", send_go, 0);
    chk("rst_send_data", send_data, 0);
`ifdef UART_ARB_TIMEOUT_EN
    chk("rst_err", err, 0);
`endif
    rst_n = 1'b1;

    // Single request, latency and single-cycle launch
    @(posedge sys_clk); #1;
    req_data[23:16] = 8'hA5;
    push(2'd2, 8'hA5);
    req = 4'b0100;
    @(posedge sys_clk); #1;
    chk("latency_send_go", send_go, 1);
    chk("launch_busy", busy, 1);
    @(posedge sys_clk); #1;
    chk("send_go_one_cycle", send_go, 0);
    wait_idle(300);
    chk("busy_after_single", busy, 0);

    // Pointer at 3: requester 3 before 0
    req_data = 32'h5A0000C3;
    push(2'd3, 8'h5A);
    push(2'd0, 8'hC3);
    req = 4'b1001;
    wait_idle(400);

    // Reset pulse then all held: order 0,1,2,3,0
    rst_n = 1'b0;
    @(posedge sys_clk); #1;
    rst_n = 1'b1;
    hold_req = 1'b1;
    req_data = 32'h44332211;
    push(2'd0, 8'h11);
    push(2'd1, 8'h22);
    push(2'd2, 8'h33);
    push(2'd3, 8'h44);
    push(2'd0, 8'h11);
    base = n_launch;
    req = 4'b1111;
    i = 0;
    while (n_launch < base + 5 && i < 1000) begin
      @(negedge sys_clk);
      i++;
    end
    if (i >= 1000) fail_now("held_launch_timeout");
    req = 4'b0000;
    hold_req = 1'b0;
    wait_idle(300);

    // Stale tx_done in IDLE
    tx_done = 1'b1;
    @(posedge sys_clk); #1;
    tx_done = 1'b0;
    chk("stale_idle_busy", busy, 0);
    @(posedge sys_clk); #1;
    chk("stale_idle_busy2", busy, 0);
    chk("stale_idle_ack", ack, 0);

    // Stale tx_done in LAUNCH
    auto_tx = 1'b0;
    req_data[15:8] = 8'h3C;
    push(2'd1, 8'h3C);
    req = 4'b0010;
    @(posedge sys_clk); #1;
    tx_done = 1'b1;
    @(posedge sys_clk); #1;
    tx_done = 1'b0;
    for (int k = 0; k < 5; k++) begin
      chk("stale_launch_ack", ack, 0);
      chk("stale_launch_busy", busy, 1);
      @(posedge sys_clk); #1;
    end
    tx_done = 1'b1;
    @(posedge sys_clk); #1;
    tx_done = 1'b0;
    wait_idle(100);

    // Reset mid-WAIT: no ack, pointer back to 0
    req_data[31:24] = 8'h77;
    exp_launch_q.push_back({2'd3, 8'h77});
    req = 4'b1000;
    i = 0;
    while (!busy && i < 50) begin
      @(posedge sys_clk); #1;
      i++;
    end
    if (i >= 50) fail_now("busy_wait_timeout");
    repeat (5) @(posedge sys_clk);
    #1;
    rst_n = 1'b0;
    req = 4'b0000;
    #1;
    chk("midrst_ack", ack, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_gnt_id", gnt_id, 0);
    chk("midrst_send_go", send_go, 0);
    chk("midrst_send_data", send_data, 0);
    @(posedge sys_clk); #1;
    rst_n = 1'b1;
    auto_tx = 1'b1;
    req_data = 32'h99006600;
    push(2'd1, 8'h66);
    push(2'd3, 8'h99);
    req = 4'b1010;
    wait_idle(400);

`ifdef UART_ARB_TIMEOUT_EN
    // Timeout: err with ack exactly 100 cycles after entering WAIT
    auto_tx = 1'b0;
    req_data[7:0] = 8'hE1;
    push(2'd0, 8'hE1);
    base = n_launch;
    req = 4'b0001;
    i = 0;
    while (n_launch == base && i < 50) begin
      @(negedge sys_clk);
      i++;
    end
    if (i >= 50) fail_now("tmo_launch_timeout");
    i = 0;
    while (!err && i < 300) begin
      @(negedge sys_clk);
      i++;
    end
    if (i >= 300) fail_now("err_timeout");
    chk("err_cycles", cyc - go_cyc, 101);
    @(negedge sys_clk);
    chk("err_one_cycle", err, 0);
    auto_tx = 1'b1;
    req_data[23:16] = 8'hB2;
    push(2'd2, 8'hB2);
    req = 4'b0100;
    wait_idle(300);
`endif

    chk("launch_q_empty", exp_launch_q.size(), 0);
    chk("ack_q_empty", exp_ack_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
